// File: rtl/tensor_addr_gen.sv
// img2col tensor-address walker: emits one SRAM read address per accepted beat, tagged with S2P lane and group/row/last flags.
// Optional TADDR_GRP_PAD_EN pads every row with dummy beats up to a multiple of S2P.
module tensor_addr_gen #(
   parameter int TENSOR_W   = 8,
   parameter int KERNEL_W   = 4,
   parameter int CHANNELS_W = 8,
   parameter int STRIDE_W   = 4,
   parameter int ADDR_W     = 20,
   parameter int S2P        = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     enable,
   input  logic [TENSOR_W-1:0]      tensor_size,
   input  logic [KERNEL_W-1:0]      kernel_size,
   input  logic [CHANNELS_W-1:0]    channels,
   input  logic [STRIDE_W-1:0]      stride,
   input  logic [TENSOR_W-1:0]      out_dim_m1,
   output logic                     addr_valid,
   input  logic                     addr_ready,
   output logic [ADDR_W-1:0]        addr,
   output logic [$clog2(S2P)-1:0]   addr_lane,
   output logic                     addr_grp_last,
   output logic                     addr_row_last,
   output logic                     addr_last,
   output logic                     addr_pad,
   output logic                     busy,
   output logic                     done
);

   localparam int LANE_W = $clog2(S2P);

   typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

   state_t state, state_nxt;
   logic   done_nxt;

   logic [TENSOR_W-1:0]   t_r, om1_r;
   logic [KERNEL_W-1:0]   k_r;
   logic [CHANNELS_W-1:0] c_r;
   logic [STRIDE_W-1:0]   s_r;
   logic [ADDR_W-1:0]     tt_r, st_r;

   logic [KERNEL_W-1:0]   kx, ky;
   logic [CHANNELS_W-1:0] ci;
   logic [TENSOR_W-1:0]   ox, oy;
   logic [ADDR_W-1:0]     base_ky, base_c, base_ox, base_oy;
   logic [LANE_W-1:0]     lane;
   logic                  pad_r;

   logic fire, kx_last, ky_last, c_last, ox_last, oy_last, row_end, lane_top;
   logic row_last_i, grp_last_i, last_i;

   assign fire     = addr_valid & addr_ready;
   assign kx_last  = (kx == k_r - KERNEL_W'(1));
   assign ky_last  = (ky == k_r - KERNEL_W'(1));
   assign c_last   = (ci == c_r - CHANNELS_W'(1));
   assign ox_last  = (ox == om1_r);
   assign oy_last  = (oy == om1_r);
   assign row_end  = kx_last & ky_last & c_last;
   assign lane_top = (lane == LANE_W'(S2P - 1));

`ifdef TADDR_GRP_PAD_EN
   // The row closes on the lane S2P-1 beat, whether that is the last real beat or a pad beat.
   assign row_last_i = lane_top & (pad_r | row_end);
   assign grp_last_i = lane_top;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         pad_r <= 1'b0;
      else if (state == INIT)
         pad_r <= 1'b0;
      else if (fire) begin
         if (pad_r) begin
            if (lane_top)
               pad_r <= 1'b0;
         end else if (row_end && !lane_top) begin
            pad_r <= 1'b1;
         end
      end
   end
`else
   assign row_last_i = row_end;
   assign grp_last_i = lane_top | row_end;
   assign pad_r      = 1'b0;
`endif

   assign last_i = row_last_i & ox_last & oy_last;

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: state_nxt = INIT;
            INIT: begin
               if (k_r == '0 || c_r == '0) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = RUN;
               end
            end
            RUN: begin
               if (fire && last_i) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
               end
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         lane <= '0;
      else if (state == INIT)
         lane <= '0;
      else if (fire)
         lane <= row_last_i ? '0 : lane + LANE_W'(1);
   end

   // Parameter capture, INIT products and the walk counters; only the FSM gates their use.
   always_ff @(posedge clk) begin
      if (state == IDLE && enable) begin
         t_r   <= tensor_size;
         k_r   <= kernel_size;
         c_r   <= channels;
         s_r   <= stride;
         om1_r <= out_dim_m1;
      end
      if (state == INIT) begin
         tt_r    <= ADDR_W'(t_r) * ADDR_W'(t_r);
         st_r    <= ADDR_W'(s_r) * ADDR_W'(t_r);
         kx      <= '0;
         ky      <= '0;
         ci      <= '0;
         ox      <= '0;
         oy      <= '0;
         base_ky <= '0;
         base_c  <= '0;
         base_ox <= '0;
         base_oy <= '0;
      end else if (state == RUN && fire) begin
         if (!pad_r) begin
            if (!kx_last) begin
               kx <= kx + KERNEL_W'(1);
            end else begin
               kx <= '0;
               if (!ky_last) begin
                  ky      <= ky + KERNEL_W'(1);
                  base_ky <= base_ky + ADDR_W'(t_r);
               end else begin
                  ky      <= '0;
                  base_ky <= '0;
                  if (!c_last) begin
                     ci     <= ci + CHANNELS_W'(1);
                     base_c <= base_c + tt_r;
                  end else begin
                     ci     <= '0;
                     base_c <= '0;
                  end
               end
            end
         end
         if (row_last_i) begin
            if (!ox_last) begin
               ox      <= ox + TENSOR_W'(1);
               base_ox <= base_ox + ADDR_W'(s_r);
            end else begin
               ox      <= '0;
               base_ox <= '0;
               oy      <= oy + TENSOR_W'(1);
               base_oy <= base_oy + st_r;
            end
         end
      end
   end

   assign addr_valid    = (state == RUN);
   assign busy          = (state == INIT) || (state == RUN);
   assign addr          = (addr_valid && !pad_r) ?
                          (base_oy + base_c + base_ky + base_ox + ADDR_W'(kx)) : '0;
   assign addr_lane     = addr_valid ? lane : '0;
   assign addr_grp_last = addr_valid & grp_last_i;
   assign addr_row_last = addr_valid & row_last_i;
   assign addr_last     = addr_valid & last_i;
   assign addr_pad      = addr_valid & pad_r;

endmodule

// File: doc/tensor_addr_gen.md
Name: tensor_addr_gen

Overview:
- Consumer-side partner of the parameter-prepare stage. Starts when `enable` rises, then walks the img2col patch sequence of the input tensor.
- Emits one tensor SRAM read address per accepted beat over a valid/ready interface.
- Each beat is tagged with its S2P lane index and with group-end, row-end and last flags, for the downstream serial-to-parallel packer feeding the GEMM array.

Parameters:
- TENSOR_W, 8, width of tensor_size
- KERNEL_W, 4, width of kernel_size
- CHANNELS_W, 8, width of channels
- STRIDE_W, 4, width of stride
- ADDR_W, 20, tensor SRAM address width
- S2P, 8, lanes per parallel group; power of two, ≥2

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- enable  in  1  parameters valid; level; deassert = abort/clear
- tensor_size  in  TENSOR_W  T, square tensor side
- kernel_size  in  KERNEL_W  K, square kernel side
- channels  in  CHANNELS_W  C
- stride  in  STRIDE_W  S
- out_dim_m1  in  TENSOR_W  output side minus 1 (O-1)
- addr_valid  out  1  beat valid
- addr_ready  in  1  consumer accepts beat
- addr  out  ADDR_W  tensor element address
- addr_lane  out  log2(S2P)  lane index within current group
- addr_grp_last  out  1  final beat of an S2P group
- addr_row_last  out  1  final beat of an img2col row (one output pixel)
- addr_last  out  1  final beat of whole sequence
- addr_pad  out  1  dummy beat (optional feature only; else tied 0)
- busy  out  1  high from INIT through RUN
- done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset is stated exactly as: reset rstn, asynchronous, active-low; clock clk.
- Reset values: all outputs 0; FSM = IDLE.
- Inputs sampled once, in IDLE on the cycle `enable` is seen high. They are held in internal registers, so later input changes are ignored until the next start.
- FSM states: IDLE → INIT → RUN → DONE.
  - IDLE → INIT: enable=1.
  - INIT, one cycle: registers TT=T*T, ST=S*T, row pitch T; all walk counters cleared. → RUN.
  - RUN → DONE: handshake on the beat with addr_last=1. `done` pulses in the cycle DONE is entered.
  - DONE holds until enable=0, then → IDLE.
- Abort: enable=0 in any state → IDLE next cycle; addr_valid=0 next cycle. The beat pending at that edge is dropped and no done pulse is issued.
- Walk order: kx fastest, then ky, then c, then ox, then oy (oy slowest).
  - One row = K*K*C beats; O*O rows in total.
- Address: addr = c*TT + (oy*S+ky)*T + (ox*S+kx).
  - Computed incrementally with adders only (base registers per loop level, no multiplier in the loop).
  - Truncated to ADDR_W.
- Handshake:
  - A beat transfers when addr_valid && addr_ready.
  - While addr_valid=1 && addr_ready=0, all addr_* outputs are held stable.
  - addr_valid is asserted throughout RUN. Zero-bubble throughput: one beat per cycle under continuous ready.
- Lane counter:
  - Increments per transferred beat, wrapping at S2P-1.
  - Resets to 0 after the row-last beat, so every row starts at lane 0.
- Flags:
  - addr_grp_last = (lane==S2P-1) || row-last.
  - addr_row_last on beat kx=ky=K-1, c=C-1.
  - addr_last = row-last at ox=oy=O-1.
- Degenerate inputs: K=1, C=1 or O=1 give rows of 1 beat or a single row, with flags coincident on the same beat.
  - K=0 or C=0: INIT goes straight to DONE (done pulse, no beats).
- busy = 1 in INIT and RUN.

Optional Feature:
- Macro: TADDR_GRP_PAD_EN.
- Defined:
  - After the row-last real beat, if lane≠S2P-1, the generator emits dummy beats with addr_pad=1 and addr=0 until lane S2P-1, so every row is a multiple of S2P beats.
  - addr_row_last and addr_grp_last move to the final pad beat. addr_last is on the final pad beat of the last row.
  - Pad beats obey the same handshake.
- Undefined: no pad beats; addr_pad tied 0.

Test Plan:
- T=4, K=3, C=1, S=1, out_dim_m1=1, ready=1 → 36 beats.
  - Row0: 0,1,2,4,5,6,8,9,10.
  - Row1: 1,2,3,5,6,7,9,10,11.
  - Row3 ends at 15 with addr_last=1; done pulses one cycle later.
- Same setup, S2P=8, macro off → beat 8 of each row: lane 7, grp_last=1. Beat 9: lane 0, grp_last=1, row_last=1.
- Same setup, macro on → 16 beats/row; beats 10–16 have addr_pad=1, addr=0; row_last on beat 16; 64 beats total.
- T=3, K=2, C=2, S=1, out_dim_m1=1 → row0: 0,1,3,4,9,10,12,13. Then T=5, K=3, S=2, C=1, out_dim_m1=1 → row starts 0, 2, 10, 12.
- Random addr_ready (~50%) on case 1 → same 36-address sequence; outputs stable during every stall; zero drops or duplicates.
- enable dropped mid-row 2 → addr_valid=0 next cycle, no done. Re-enable → sequence restarts from addr 0, lane 0.
